// File: rtl/add_sub_pkg.sv
// Shared constants and result type for the add/subtract unit.
package add_sub_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Reference result layout at the default 4-bit width.
  localparam int ADDSUB_W = 4;

  typedef struct packed {
    logic                carry;
    logic [ADDSUB_W-1:0] sum;
  } addsub_res_t;
endpackage

// File: rtl/add_sub_unit_full_adder.sv
// One-bit full adder stage of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/add_sub_unit.sv
// Registered two's-complement adder/subtractor on a single ripple chain.
// Optional build macro ADDSUB_OVF_EN adds a registered signed-overflow flag (ovf).
module add_sub_unit
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] out,
  output logic             o,
`ifdef ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  // Subtract is a + ~b + 1: invert b and feed s in as the chain's carry-in.
  assign b_eff    = (s == OP_SUB) ? ~b : b;
  assign carry[0] = s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b_eff[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      o         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= sum;
        o   <= carry[WIDTH];
      end
    end
  end

`ifdef ADDSUB_OVF_EN
  // Carry into and out of the MSB disagree exactly on signed overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf <= 1'b0;
    else if (in_valid) ovf <= carry[WIDTH-1] ^ carry[WIDTH];
  end
`endif
endmodule

// File: tb/tb_add_sub_unit.sv
// Directed and random checks of add_sub_unit at WIDTH=4.
module tb_add_sub_unit;
  import add_sub_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic       s = 1'b0;
  logic [3:0] out;
  logic       o, out_valid;
`ifdef ADDSUB_OVF_EN
  logic       ovf;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  add_sub_unit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .s         (s),
    .out       (out),
    .o         (o),
`ifdef ADDSUB_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one valid op, clock it, and check the registered result.
  task automatic op(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                    input logic ts, input logic [3:0] e_out, input logic e_o);
    a = ta; b = tb; s = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".out"}, 32'(out), 32'(e_out));
    chk({tag, ".o"},   32'(o),   32'(e_o));
    chk({tag, ".vld"}, 32'(out_valid), 32'd1);
  endtask

`ifdef ADDSUB_OVF_EN
  task automatic op_ovf(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                        input logic ts, input logic [3:0] e_out, input logic e_ovf);
    a = ta; b = tb; s = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".out"}, 32'(out), 32'(e_out));
    chk({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
  endtask
`endif

  initial begin
    addsub_res_t g;
    logic [3:0] ra, rb, hold_out;
    logic       rs, hold_o;
    logic [4:0] full;

    #1;
    chk("rst.out", 32'(out), 32'd0);
    chk("rst.o",   32'(o),   32'd0);
    chk("rst.vld", 32'(out_valid), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    op("add0", 4'h0, 4'h0, OP_ADD, 4'h0, 1'b0);
    op("add1", 4'h0, 4'h1, OP_ADD, 4'h1, 1'b0);
    op("add2", 4'h6, 4'h4, OP_ADD, 4'hA, 1'b0);
    op("add3", 4'hA, 4'h4, OP_ADD, 4'hE, 1'b0);
    op("add4", 4'hC, 4'h4, OP_ADD, 4'h0, 1'b1);

    op("sub0", 4'h6, 4'h4, OP_SUB, 4'h2, 1'b1);
    op("sub1", 4'h2, 4'h4, OP_SUB, 4'hE, 1'b0);
    op("sub2", 4'h3, 4'h2, OP_SUB, 4'h1, 1'b1);
    op("sub3", 4'h5, 4'h5, OP_SUB, 4'h0, 1'b1);
    op("sub4", 4'h9, 4'h0, OP_SUB, 4'h9, 1'b1);
    op("sub5", 4'h0, 4'hF, OP_SUB, 4'h1, 1'b0);

    // Async reset asserted between edges clears outputs immediately.
    op("pre_rst", 4'h7, 4'h7, OP_ADD, 4'hE, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst.out", 32'(out), 32'd0);
    chk("mid_rst.o",   32'(o),   32'd0);
    chk("mid_rst.vld", 32'(out_valid), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

`ifdef ADDSUB_OVF_EN
    op_ovf("ovf0", 4'h6, 4'h4, OP_ADD, 4'hA, 1'b1);
    op_ovf("ovf1", 4'hC, 4'h4, OP_ADD, 4'h0, 1'b0);
    op_ovf("ovf2", 4'h8, 4'h1, OP_SUB, 4'h7, 1'b1);
    op_ovf("ovf3", 4'h2, 4'h4, OP_SUB, 4'hE, 1'b0);
`endif

    // in_valid low: outputs hold while operands churn.
    op("hold_set", 4'hC, 4'h4, OP_ADD, 4'h0, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 4'(i + 3); b = 4'(i * 5); s = i[0];
      @(posedge clk); #1;
      chk("hold.out", 32'(out), 32'h0);
      chk("hold.o",   32'(o),   32'd1);
      chk("hold.vld", 32'(out_valid), 32'd0);
    end

    // Back-to-back alternating s, then random; golden built independently.
    for (int i = 0; i < 40; i++) begin
      ra = (i < 8) ? 4'(i * 3 + 1) : 4'($urandom_range(0, 15));
      rb = (i < 8) ? 4'(7 - i)     : 4'($urandom_range(0, 15));
      rs = (i < 8) ? i[0]          : 1'($urandom_range(0, 1));
      full = rs ? ({1'b0, ra} + {1'b0, ~rb} + 5'd1) : ({1'b0, ra} + {1'b0, rb});
      g.carry = full[4];
      g.sum   = full[3:0];
      if (rs) chk("gold.c_sub", 32'(g.carry), 32'(ra >= rb));
      hold_out = g.sum; hold_o = g.carry;
      op("sweep", ra, rb, rs, hold_out, hold_o);
`ifdef ADDSUB_OVF_EN
      chk("sweep.ovf", 32'(ovf),
          32'((rs ? (ra[3] != rb[3]) : (ra[3] == rb[3])) && (g.sum[3] != ra[3])));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
